// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port indices, port count and
// the credit counter width helper.
package noc_pkg;

  // Number of router ports (local plus four mesh directions).
  localparam int NUM_PORTS = 5;

  // Port index order used for every request/grant vector in the router.
  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  // Bits needed to hold a credit count in the range 0..depth.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Bundle between the input-port side (routing, buffers) and the switch
// allocator (crossbar selects, buffer pops, debug view of per-output state).
//
// Handshake: there is no valid/ready pair. A non-zero request row is the
// valid for that input's head flit. The matching o_input_grant bit is the
// same-cycle acceptance, and the buffer pops on the following clock edge.
// i_credit is a single-cycle pulse, one credit per asserted cycle.
interface switch_allocator_if
  import noc_pkg::*;
#(
  parameter int M  = NUM_PORTS,
  parameter int CW = 3
);
  logic [0:M-1][0:M-1]    i_output_req;
  logic [0:M-1]           i_head;
  logic [0:M-1]           i_tail;
  logic [0:M-1]           i_credit;
  logic [0:M-1][0:M-1]    o_grant;
  logic [0:M-1]           o_input_grant;
  logic [0:M-1][CW-1:0]   dbg_credits;
  logic [0:M-1]           dbg_lock;

  // Router side: drives flit requests and credit returns.
  modport master (
    output i_output_req, i_head, i_tail, i_credit,
    input  o_grant, o_input_grant, dbg_credits, dbg_lock
  );

  // Allocator side.
  modport slave (
    input  i_output_req, i_head, i_tail, i_credit,
    output o_grant, o_input_grant, dbg_credits, dbg_lock
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after the
// pointer position, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  int   c;
  logic found;

  // Scan ptr+1, ptr+2, ... and grant the first requester found.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(i_ptr) + k) % N;
      if (i_en && !found && i_req[c]) begin
        found    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IW'(c);
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin among head flits,
// output locked to one input from head to tail, grants gated by credits.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int M     = NUM_PORTS,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  switch_allocator_if.slave bus
);
  localparam int CW = credit_w(DEPTH);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  logic [M-1:0][IW-1:0] ptr_q, ptr_d;
  logic [M-1:0][IW-1:0] owner_q, owner_d;
  logic [M-1:0]         lock_q, lock_d;
  logic [M-1:0][CW-1:0] credits_q, credits_d;

  logic [M-1:0][M-1:0]  elig;      // [o][i]
  logic [M-1:0]         arb_en;
  logic [M-1:0][M-1:0]  gnt;       // [o][i]
  logic [M-1:0][IW-1:0] win_idx;
  logic [M-1:0]         win;
  logic [M-1:0]         credit_ovf;

  // Eligible inputs per output: heads when unlocked, only the owner when locked.
  always_comb begin
    elig   = '0;
    arb_en = '0;
    for (int o = 0; o < M; o++) begin
      arb_en[o] = !reset && (credits_q[o] != '0);
      for (int i = 0; i < M; i++) begin
        if (lock_q[o]) begin
          elig[o][i] = (owner_q[o] == IW'(i)) && bus.i_output_req[i][o];
        end else begin
          elig[o][i] = bus.i_output_req[i][o] && bus.i_head[i];
        end
      end
    end
  end

  for (genvar go = 0; go < M; go++) begin : g_arb
    rr_arbiter #(.N(M), .IW(IW)) u_arb (
      .i_req (elig[go]),
      .i_ptr (ptr_q[go]),
      .i_en  (arb_en[go]),
      .o_gnt (gnt[go]),
      .o_idx (win_idx[go])
    );
  end

  // Crossbar selects and per-input pop strobes.
  always_comb begin
    bus.o_grant       = '0;
    bus.o_input_grant = '0;
    win               = '0;
    for (int o = 0; o < M; o++) begin
      win[o] = |gnt[o];
      for (int i = 0; i < M; i++) begin
        bus.o_grant[o][i]    = gnt[o][i];
        bus.o_input_grant[i] = bus.o_input_grant[i] | gnt[o][i];
      end
    end
  end

  // Next pointer, lock/owner and credit count for each output.
  always_comb begin
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    credits_d  = credits_q;
    credit_ovf = '0;
    for (int o = 0; o < M; o++) begin
      if (win[o]) begin
        ptr_d[o] = win_idx[o];
        if (bus.i_tail[win_idx[o]]) begin
          lock_d[o] = 1'b0;
        end else if (bus.i_head[win_idx[o]]) begin
          lock_d[o]  = 1'b1;
          owner_d[o] = win_idx[o];
        end
      end
      if (win[o] && !bus.i_credit[o]) begin
        credits_d[o] = credits_q[o] - CW'(1);
      end else if (!win[o] && bus.i_credit[o]) begin
        // A return beyond DEPTH is a downstream protocol error; hold at DEPTH.
        if (credits_q[o] == CW'(DEPTH)) begin
          credit_ovf[o] = 1'b1;
        end else begin
          credits_d[o] = credits_q[o] + CW'(1);
        end
      end
    end
  end

  // State registers; reset drops any lock and refills credits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < M; o++) begin
        ptr_q[o]     <= IW'(M - 1);
        owner_q[o]   <= '0;
        credits_q[o] <= CW'(DEPTH);
      end
      lock_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      credits_q <= credits_d;
    end
  end

  // Debug view of per-output state.
  always_comb begin
    bus.dbg_credits = '0;
    bus.dbg_lock    = '0;
    for (int o = 0; o < M; o++) begin
      bus.dbg_credits[o] = credits_q[o];
      bus.dbg_lock[o]    = lock_q[o];
    end
  end

  for (genvar ga = 0; ga < M; ga++) begin : g_ovf_chk
    a_credit_ovf : assert property (@(posedge clk) disable iff (reset) !credit_ovf[ga]);
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: priority after reset, wormhole
// locking, credit stall/return, round-robin rotation and reset mid-packet.
module tb_switch_allocator;
  import noc_pkg::*;

  localparam int M     = NUM_PORTS;
  localparam int DEPTH = 4;
  localparam int CW    = credit_w(DEPTH);
  localparam int W     = M * M;

  typedef logic [0:M-1][0:M-1] gmat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];
  int   stall_n;

  switch_allocator_if #(.M(M), .CW(CW)) bus ();

  switch_allocator #(.M(M), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic gmat_t g(input int o, input int i);
    gmat_t r;
    r = '0;
    r[o][i] = 1'b1;
    return r;
  endfunction

  task automatic clear_in();
    bus.i_output_req = '0;
    bus.i_head       = '0;
    bus.i_tail       = '0;
    bus.i_credit     = '0;
  endtask

  task automatic flit(input int i, input int o, input logic h, input logic t);
    bus.i_output_req[i][o] = 1'b1;
    bus.i_head[i]          = h;
    bus.i_tail[i]          = t;
  endtask

  // Inputs are already driven; record expectation, sample, go to next negedge.
  task automatic cycle(input string tag, input gmat_t exp);
    gmat_t        e;
    logic [0:M-1] ig;
    exp_q.push_back(exp);
    #2;
    e  = exp_q.pop_front();
    ig = '0;
    for (int o = 0; o < M; o++)
      for (int i = 0; i < M; i++)
        if (e[o][i]) ig[i] = 1'b1;
    check({tag, "_grant"}, 64'(bus.o_grant), 64'(e));
    check({tag, "_in_grant"}, 64'(bus.o_input_grant), 64'(ig));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_cred(input string tag, input int o, input int exp);
    check(tag, 64'(bus.dbg_credits[o]), 64'(exp));
  endtask

  task automatic chk_lock(input string tag, input int o, input logic exp);
    check(tag, 64'(bus.dbg_lock[o]), 64'(exp));
  endtask

  initial begin
    int order[5];
    order = '{1, 2, 3, 4, 1};

    // Reset: grants gated even with live requests; state at reset values.
    clear_in();
    flit(0, EAST, 1'b1, 1'b1);
    flit(2, EAST, 1'b1, 1'b1);
    cycle("rst_gate", '0);
    for (int o = 0; o < M; o++) begin
      chk_cred("rst_cred", o, DEPTH);
      chk_lock("rst_lock", o, 1'b0);
    end

    // Reset priority: input 0 first, then input 2.
    reset = 1'b0;
    cycle("prio_c1", g(EAST, 0));
    clear_in();
    flit(2, EAST, 1'b1, 1'b1);
    cycle("prio_c2", g(EAST, 2));
    clear_in();
    chk_cred("prio_cred", EAST, 2);

    // Wormhole lock on west.
    do_reset();
    flit(1, WEST, 1'b1, 1'b0);
    flit(3, WEST, 1'b1, 1'b1);
    cycle("wh_head", g(WEST, 1));
    chk_lock("wh_locked", WEST, 1'b1);
    clear_in();
    flit(1, WEST, 1'b0, 1'b0);
    flit(3, WEST, 1'b1, 1'b1);
    cycle("wh_body", g(WEST, 1));
    clear_in();
    flit(1, WEST, 1'b0, 1'b1);
    flit(3, WEST, 1'b1, 1'b1);
    cycle("wh_tail", g(WEST, 1));
    chk_lock("wh_unlocked", WEST, 1'b0);
    clear_in();
    flit(3, WEST, 1'b1, 1'b1);
    cycle("wh_other", g(WEST, 3));
    clear_in();
    chk_cred("wh_cred", WEST, 0);

    // Credit stall: four grants, then none until a credit comes back.
    do_reset();
    stall_n = $urandom_range(1, 3);
    flit(0, NORTH, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle("stall_ok", g(NORTH, 0));
    for (int k = 0; k < stall_n; k++) cycle("stall_none", '0);
    bus.i_credit[NORTH] = 1'b1;
    cycle("stall_ret", '0);
    bus.i_credit[NORTH] = 1'b0;
    cycle("stall_use", g(NORTH, 0));
    cycle("stall_again", '0);
    clear_in();
    chk_cred("stall_cred", NORTH, 0);

    // Simultaneous grant and return leaves the count unchanged.
    do_reset();
    flit(0, NORTH, 1'b1, 1'b1);
    cycle("sim_g1", g(NORTH, 0));
    cycle("sim_g2", g(NORTH, 0));
    chk_cred("sim_cred2", NORTH, 2);
    bus.i_credit[NORTH] = 1'b1;
    cycle("sim_both", g(NORTH, 0));
    chk_cred("sim_hold", NORTH, 2);
    clear_in();
    bus.i_credit[NORTH] = 1'b1;
    cycle("sim_ret", '0);
    clear_in();
    chk_cred("sim_inc", NORTH, 3);

    // Round-robin rotation on the local output.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      clear_in();
      for (int i = 1; i < M; i++) flit(i, LOCAL, 1'b1, 1'b1);
      bus.i_credit[LOCAL] = 1'b1;
      cycle("rr", g(LOCAL, order[k]));
    end
    clear_in();
    chk_cred("rr_cred", LOCAL, DEPTH);

    // Reset in the middle of a packet.
    do_reset();
    flit(2, SOUTH, 1'b1, 1'b0);
    cycle("mid_head", g(SOUTH, 2));
    chk_lock("mid_locked", SOUTH, 1'b1);
    chk_cred("mid_cred3", SOUTH, 3);
    clear_in();
    flit(2, SOUTH, 1'b0, 1'b0);
    flit(4, SOUTH, 1'b1, 1'b1);
    reset = 1'b1;
    cycle("mid_rst", '0);
    chk_lock("mid_unlock", SOUTH, 1'b0);
    chk_cred("mid_refill", SOUTH, DEPTH);
    reset = 1'b0;
    cycle("mid_new", g(SOUTH, 4));
    clear_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-output-port wormhole switch allocator for the 5-port mesh router. It takes the one-hot output requests produced by each input port's XY routing stage and grants each output port to at most one input per cycle. Arbitration is round-robin, and each output is locked to one input from head flit to tail flit. Grants are gated by per-output credit counters that track free slots in the downstream input buffer. It sits between the input buffers and routing logic on one side, and the crossbar select and buffer read strobes on the other.

## Interface
- `M`, default `` `M `` (5): number of router ports. Index order is local, north, east, south, west.
- `DEPTH`, default 4: downstream input-buffer depth in flits. It is also the initial and maximum credit value.
- `clk` in, 1: clock.
- `reset` in, 1: asynchronous, active-high reset.
- `i_output_req` in, [0:M-1][0:M-1]: per-input one-hot output request, as produced by routing. `[i][o]` means input i requests output o. A row is all-zero when there is no flit.
- `i_head` in, [0:M-1]: the flit at the head of input i is a head flit.
- `i_tail` in, [0:M-1]: the flit at the head of input i is a tail flit. A single-flit packet has head=tail=1.
- `i_credit` in, [0:M-1]: one-cycle pulse from the downstream router. It returns one credit for output o.
- `o_grant` in/out: out, [0:M-1][0:M-1]: `[o][i]` means output o is granted to input i this cycle. Each row is one-hot or zero. Drives the crossbar select.
- `o_input_grant` out, [0:M-1]: input i's flit is forwarded this cycle. It is the OR over o of `o_grant[o][i]` and is used as the buffer pop.

## Operation
Per-output state, for each output o:
- `ptr[o]` holds the last granted input index.
- `lock[o]` is a flag.
- `owner[o]` holds the locked input index.
- `credits[o]` ranges 0..DEPTH and is `$clog2(DEPTH+1)` bits wide.

Per cycle, for each output o:
- **Eligible set**, unlocked output: inputs i with `i_output_req[i][o] && i_head[i]`. Body and tail flits never win an unlocked output.
- **Eligible set**, locked output: only `owner[o]`, and only if `i_output_req[owner][o]`. Heads from other inputs wait.
- **Credit gate:** if `credits[o]==0`, no grant is issued for o.
- **Winner, unlocked case:** the first eligible input scanning `ptr+1, ptr+2, …` modulo M.
- **On a grant:**
  - `ptr[o]` takes the winner index.
  - `credits[o]` decrements.
  - If the flit is a head and not a tail, set `lock[o]` and `owner[o]`=winner.
  - If the flit is a tail, clear `lock[o]`.
  - A single-flit packet therefore never locks.
- **Credit arithmetic:**
  - next = credits − grant + `i_credit[o]`.
  - A grant and a credit return in the same cycle leave the count unchanged.
  - A return that would exceed DEPTH is a protocol error: the count holds at DEPTH and a simulation assertion fires.
- **Ports:** because routing rows are one-hot, each input wins at most one output. No input-side arbitration is needed.
- **Reset values:**
  - `ptr[o]`=M−1, so input 0 (local) has first priority.
  - `lock`=0, `owner`=0, `credits`=DEPTH.
  - `o_grant` and `o_input_grant` are all zero while `reset` is high, regardless of inputs.
- **Reset mid-packet:** the lock is dropped and credits return to DEPTH. The upstream and downstream routers are reset by the same signal.

## Timing
- Grants are combinational from the current inputs and registered state, with zero-cycle latency. The flit is forwarded in the same cycle it is granted.
- State (`ptr`, `lock`, `owner`, `credits`) updates on the rising edge of `clk`.
- A credit returned in cycle t is usable for a grant in cycle t+1.
- A locked owner with a bubble (row zero) keeps the lock. Other inputs are not granted that output until the owner's tail is granted.
- Fairness: an eligible head is granted on output o within M−1 competing packets.

## Structure
- **Shared package `noc_pkg`:**
  - Port index enum: LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - Port count M.
  - Credit-width function/constant.
- **Sub-module `rr_arbiter`:**
  - Parameter N.
  - Inputs: request [N], pointer, enable.
  - Outputs: one-hot grant and winner index.
  - It is purely combinational and instantiated M times via generate.
- **Top module:** holds all registers and the lock/credit logic.

## Test plan
- **Reset priority.** Release reset. Inputs 0 and 2 both request east (output 2) with single-flit packets.
  - Cycle 1: grant [2][0].
  - Cycle 2: grant [2][2].
  - credits[2] goes 4→2.
- **Wormhole lock.** Input 1 sends head, body, tail to west. Input 3 sends a head to west from cycle 1.
  - Input 1 is granted for 3 consecutive cycles.
  - Input 3 is granted in cycle 4.
- **Credit stall.** Five single flits go from local to north with no `i_credit`.
  - Four grants are issued, then none.
  - A pulse on `i_credit[1]` yields exactly one further grant on the next cycle.
- **Simultaneous grant and return.** With credits=2, a grant and `i_credit` occur in the same cycle. Credits stay at 2.
- **Round-robin rotation.** All four non-local inputs continuously request local (output 0) with single flits. Grant order is 1, 2, 3, 4, 1.
- **Reset mid-packet.**
  - Assert reset after a head is granted to south, with the lock set and credits=3.
  - All grants drop immediately.
  - After release, the lock is clear and credits=4.
  - A new head from a different input is granted at once.
